// File: rtl/twos_to_sign_mag.sv
// Purpose : bit-serial two's-complement to sign-magnitude decoder, LSB first.
// Latency : done pulses WIDTH+1 edges after the accepting edge; next accept WIDTH+2 edges after it.
// Backpr. : start is taken only while ready=1; start while busy is ignored, A is not re-sampled.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset; aborts any conversion in flight
//   start - conversion request, accepted when ready=1
//   A     - WIDTH-bit two's-complement operand, sampled on the accepting edge
//   ready - high while idle
//   done  - one-cycle pulse, sign/mag carry a fresh result
//   sign  - 1 = operand was negative
//   mag   - unsigned magnitude (most-negative input gives 2^(WIDTH-1), no overflow)
//
// Build option: TWOS_TO_SIGN_MAG_FAST_POS_EN - non-negative operands bypass the
// serial path and complete with done one edge after acceptance.
module twos_to_sign_mag #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             ready,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] mag
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mag;
    logic [CNT_W-1:0] r_count;
    logic             r_sign_lat;
    logic             r_seen_one;
    logic             r_sign;
    logic             r_done;
    logic             r_fast;

    logic             w_accept;
    logic             w_last;
    logic             w_bit;
    logic             w_obit;
    logic             w_fast_pos;
    logic [WIDTH-1:0] w_result_nxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_count == CNT_W'(WIDTH - 1));

    // Copy bits up to and including the first 1, invert the rest -- but only
    // when the operand is negative; positive operands pass straight through.
    assign w_bit        = r_shift[0];
    assign w_obit       = w_bit ^ (r_sign_lat & r_seen_one);
    // Fill from the MSB so the first (LSB) output bit lands at bit 0 after WIDTH shifts.
    assign w_result_nxt = {w_obit, r_result[WIDTH-1:1]};

`ifdef TWOS_TO_SIGN_MAG_FAST_POS_EN
    assign w_fast_pos = ~A[WIDTH-1];
`else
    assign w_fast_pos = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_fast_pos ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_result   <= '0;
            r_mag      <= '0;
            r_count    <= '0;
            r_sign_lat <= 1'b0;
            r_seen_one <= 1'b0;
            r_sign     <= 1'b0;
            r_done     <= 1'b0;
            r_fast     <= 1'b0;
        end else begin
            // The serial path raises done one edge after the DONE state so the
            // pulse lines up with the first idle cycle; this keeps back-to-back
            // throughput at WIDTH+2 edges while giving WIDTH+1 edges of latency.
            // The fast path raises it straight from the accepting edge and the
            // r_fast flag stops the DONE state from pulsing a second time.
            r_done <= (w_accept & w_fast_pos) | ((r_state == S_DONE) & ~r_fast);

            if (w_accept) begin
                r_shift    <= A;
                r_sign_lat <= A[WIDTH-1];
                r_seen_one <= 1'b0;
                r_count    <= '0;
                r_fast     <= w_fast_pos;
                if (w_fast_pos) begin
                    r_mag  <= A;
                    r_sign <= 1'b0;
                end
            end else if (r_state == S_SHIFT) begin
                r_shift    <= r_shift >> 1;
                r_result   <= w_result_nxt;
                r_seen_one <= r_seen_one | w_bit;
                r_count    <= r_count + 1'b1;
                // Outputs hold the previous result until this edge enters DONE.
                if (w_last) begin
                    r_mag  <= w_result_nxt;
                    r_sign <= r_sign_lat;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        ready = (r_state == S_IDLE);
        done  = r_done;
        sign  = r_sign;
        mag   = r_mag;
    end

endmodule
